// File: rtl/lm_sm_sequencer.sv
// LM/SM register-list sequencer: walks the set bits of an 8-bit register mask
// lowest-first, issuing one register index and incrementing address per cycle.
module lm_sm_sequencer #(
   parameter int AW   = 16,
   parameter int NREG = 8,
   localparam int IW  = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NREG-1:0] reg_list,
   input  logic [AW-1:0] base_addr,
   input  logic          adv,
   input  logic          flush,
   output logic          valid,
   output logic [IW-1:0] reg_idx,
   output logic [AW-1:0] mem_addr,
   output logic          vbit,
   output logic          busy,
   output logic          done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state;
   logic [NREG-1:0] mask;
   logic [AW-1:0]   addr;
   logic            done_r;

   logic [IW-1:0]   low_idx;
   logic [NREG-1:0] rest;
   logic            run;

   // Handshake: a transfer is offered while valid=1 and is consumed on a rising
   // edge where adv=1; with adv=0 the offered transfer is held unchanged.
   always_comb begin
      low_idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (mask[i]) low_idx = IW'(i);
      end
   end

   // Clearing the lowest set bit leaves exactly the transfers still to come.
   assign rest = mask & (mask - NREG'(1));
   assign run  = (state == RUN);

   assign valid    = run;
   assign reg_idx  = run ? low_idx : '0;
   assign mem_addr = run ? addr : '0;
   assign vbit     = run && (rest != '0);
   assign busy     = run;
   assign done     = done_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mask   <= '0;
         addr   <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (flush) begin
            state <= IDLE;
            mask  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (reg_list != '0) begin
                        mask  <= reg_list;
                        addr  <= base_addr;
                        state <= RUN;
                     end else begin
                        done_r <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (adv) begin
                     mask <= rest;
                     addr <= addr + AW'(1);
                     if (rest == '0) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Randomized bench for lm_sm_sequencer against a transfer-list reference model.
module tb_lm_sm_sequencer;

   localparam int AW = 16;
   localparam int NREG = 8;
   localparam int W = 3 + AW + 1;   // {reg_idx, mem_addr, vbit}

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    reg_list;
   logic [AW-1:0] base_addr;
   logic          adv;
   logic          flush;
   logic          valid;
   logic [2:0]    reg_idx;
   logic [AW-1:0] mem_addr;
   logic          vbit;
   logic          busy;
   logic          done;

   logic [W-1:0]  exp_q[$];
   logic          pending_done;
   int            n_checks = 0;
   int            n_pass = 0;

   lm_sm_sequencer #(.AW(AW), .NREG(NREG)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .reg_list(reg_list),
      .base_addr(base_addr), .adv(adv), .flush(flush), .valid(valid),
      .reg_idx(reg_idx), .mem_addr(mem_addr), .vbit(vbit), .busy(busy),
      .done(done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference: the list expands to one transfer per set bit, lowest bit first,
   // at consecutive addresses; vbit is set on all but the last.
   task automatic build_model(input logic [7:0] list, input logic [AW-1:0] base);
      int k;
      int n;
      logic [AW-1:0] a;
      k = $countones(list);
      n = 0;
      exp_q.delete();
      for (int i = 0; i < NREG; i++) begin
         if (list[i]) begin
            a = base + AW'(n);
            exp_q.push_back({3'(i), a, (n < k - 1) ? 1'b1 : 1'b0});
            n++;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_vbit"}, vbit, 0);
      check({tag, "_idx"}, reg_idx, 0);
      check({tag, "_addr"}, mem_addr, 0);
   endtask

   // driver: one IDLE cycle with start low
   task automatic idle_cycle();
      start = 1'b0;
      flush = 1'b0;
      adv = 1'($urandom_range(0, 1));
      reg_list = 8'($urandom);
      base_addr = AW'($urandom);
      @(negedge clk);
      check_idle("idle");
      check("idle_done", done, {31'd0, pending_done});
      pending_done = 1'b0;
      @(posedge clk); #1;
   endtask

   // driver: launch one sequence from IDLE and follow it to its end
   task automatic run_seq(input logic [7:0] list, input logic [AW-1:0] base,
                          input int adv_pct, input int hold,
                          input int flush_at, input int rst_at);
      int n_pop;
      int cyc;
      logic [W-1:0] e;
      build_model(list, base);
      start = 1'b1;
      reg_list = list;
      base_addr = base;
      flush = 1'b0;
      adv = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle("launch");
      check("launch_done", done, {31'd0, pending_done});
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
         pending_done = 1'b1;
         return;
      end
      n_pop = 0;
      cyc = 0;
      while (exp_q.size() > 0) begin
         if (cyc >= 200) begin
            check("timeout", 1, 0);
            exp_q.delete();
            pending_done = 1'b0;
            return;
         end
         // start and operand changes during a sequence must be ignored
         start = 1'($urandom_range(0, 1));
         reg_list = 8'($urandom);
         base_addr = AW'($urandom);
         adv = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < adv_pct);
         flush = (n_pop == flush_at);
         if (n_pop == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check_idle("rst");
            check("rst_done", done, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            start = 1'b0;
            exp_q.delete();
            pending_done = 1'b0;
            return;
         end
         e = exp_q[0];
         @(negedge clk);
         check("xfer_valid", valid, 1);
         check("xfer_idx", reg_idx, e[W-1 -: 3]);
         check("xfer_addr", mem_addr, e[AW:1]);
         check("xfer_vbit", vbit, e[0]);
         check("xfer_busy", busy, 1);
         check("xfer_done", done, 0);
         @(posedge clk); #1;
         if (flush) begin
            flush = 1'b0;
            exp_q.delete();
            pending_done = 1'b0;
            return;
         end
         if (adv) begin
            void'(exp_q.pop_front());
            n_pop++;
         end
         cyc++;
      end
      pending_done = 1'b1;
   endtask

   initial begin
      int pct;
      int fa;
      logic [7:0] l;
      rst_n = 1'b0;
      start = 1'b0;
      reg_list = '0;
      base_addr = '0;
      adv = 1'b0;
      flush = 1'b0;
      pending_done = 1'b0;
      @(negedge clk);
      check_idle("reset");
      check("reset_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycle();

      run_seq(8'h25, 16'h0100, 100, 0, -1, -1);
      idle_cycle();
      run_seq(8'hFF, 16'hFFFE, 100, 0, -1, -1);
      idle_cycle();
      run_seq(8'h81, 16'h1234, 100, 3, -1, -1);
      idle_cycle();
      run_seq(8'h00, 16'h5555, 100, 0, -1, -1);
      idle_cycle();
      run_seq(8'h0F, 16'h0200, 100, 0, 1, -1);
      idle_cycle();
      run_seq(8'h0F, 16'h0300, 100, 0, -1, 1);
      idle_cycle();
      // flush coinciding with the final advance
      run_seq(8'h06, 16'h0400, 100, 0, 1, -1);
      idle_cycle();
      // back-to-back: next start issued in the done cycle
      run_seq(8'h25, 16'h0100, 100, 0, -1, -1);
      run_seq(8'hC3, 16'hFFFF, 100, 0, -1, -1);
      run_seq(8'h00, 16'h0000, 100, 0, -1, -1);
      idle_cycle();

      for (int r = 0; r < 40; r++) begin
         l = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         pct = $urandom_range(30, 100);
         fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
         run_seq(l, AW'($urandom), pct, $urandom_range(0, 2), fa, -1);
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
